// File: rtl/gamma_cp_deserializer.sv
// Re-assembles serial colour planes from the gamma corrector into one parallel pixel.
// Broken plane sequences are dropped and counted, and the block resynchronises on the next plane 0.
module gamma_cp_deserializer #(
  parameter int DATA_WIDTH   = 10,
  parameter int CPSEL_WIDTH  = 2,
  parameter int NUM_CP       = 3,
  parameter int ERRCNT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    ce,
  input  logic                    inpvalid,
  input  logic [CPSEL_WIDTH-1:0]  cpin,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic                    clr_err,
  output logic                    outvalid,
  output logic [DATA_WIDTH-1:0]   dout0,
  output logic [DATA_WIDTH-1:0]   dout1,
  output logic [DATA_WIDTH-1:0]   dout2,
  output logic                    seqerr,
  output logic [ERRCNT_WIDTH-1:0] errcnt
);

  typedef enum logic [1:0] {
    EXP0 = 2'd0,
    EXP1 = 2'd1,
    EXP2 = 2'd2
  } state_t;

  localparam logic [CPSEL_WIDTH-1:0]  LAST_CP = CPSEL_WIDTH'(NUM_CP - 1);
  localparam logic [ERRCNT_WIDTH-1:0] ERR_MAX = '1;

  state_t                  state;
  state_t                  state_nxt;
  logic [CPSEL_WIDTH-1:0]  exp_cp;
  logic                    last_plane;
  logic                    seq_err;
  logic                    cap0_en;
  logic                    cap1_en;
  logic [DATA_WIDTH-1:0]   cap0;
  logic [DATA_WIDTH-1:0]   cap1;

  // A tag >= NUM_CP can never equal the expected plane, so one compare covers both error cases.
  always_comb begin
    state_nxt  = state;
    exp_cp     = '0;
    last_plane = 1'b0;
    seq_err    = 1'b0;
    cap0_en    = 1'b0;
    cap1_en    = 1'b0;

    case (state)
      EXP0:    exp_cp = CPSEL_WIDTH'(0);
      EXP1:    exp_cp = CPSEL_WIDTH'(1);
      EXP2:    exp_cp = CPSEL_WIDTH'(2);
      default: exp_cp = '0;
    endcase

    if (inpvalid) begin
      if (cpin == exp_cp) begin
        if (cpin == LAST_CP) begin
          last_plane = 1'b1;
          state_nxt  = EXP0;
        end else begin
          cap0_en   = (state == EXP0);
          cap1_en   = (state == EXP1);
          state_nxt = (state == EXP0) ? EXP1 : EXP2;
        end
      end else begin
        seq_err = 1'b1;
        if (cpin == '0) begin
          cap0_en   = 1'b1;
          state_nxt = EXP1;
        end else begin
          state_nxt = EXP0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= EXP0;
    end else if (ce) begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      outvalid <= 1'b0;
      cap0     <= '0;
      cap1     <= '0;
      dout0    <= '0;
      dout1    <= '0;
      dout2    <= '0;
      seqerr   <= 1'b0;
      errcnt   <= '0;
    end else if (ce) begin
      outvalid <= last_plane;

      if (cap0_en) begin
        cap0 <= din;
      end
      if (cap1_en) begin
        cap1 <= din;
      end

      // The final plane bypasses the capture registers and lands straight in the output.
      if (last_plane) begin
        dout0 <= cap0;
        if (NUM_CP == 3) begin
          dout1 <= cap1;
          dout2 <= din;
        end else begin
          dout1 <= din;
          dout2 <= '0;
        end
      end

      if (seq_err) begin
        seqerr <= 1'b1;
        if (clr_err) begin
          errcnt <= ERRCNT_WIDTH'(1);
        end else if (errcnt != ERR_MAX) begin
          errcnt <= errcnt + ERRCNT_WIDTH'(1);
        end
      end else if (clr_err) begin
        seqerr <= 1'b0;
        errcnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_gamma_cp_deserializer.sv
// Scoreboard bench: a 3-plane and a 2-plane instance, directed plane sequences, and
// a monitor per instance that pops expected pixels whenever a ce-qualified outvalid appears.
module tb_gamma_cp_deserializer;

  typedef struct {
    logic [9:0] d0;
    logic [9:0] d1;
    logic [9:0] d2;
    int         cyc;
  } pix_t;

  logic       clk;
  logic       rstn;
  logic       ce;
  logic       clr_err;

  logic       inpvalid_a;
  logic [1:0] cpin_a;
  logic [9:0] din_a;
  logic       outvalid_a;
  logic [9:0] dout0_a;
  logic [9:0] dout1_a;
  logic [9:0] dout2_a;
  logic       seqerr_a;
  logic [7:0] errcnt_a;

  logic       inpvalid_b;
  logic [1:0] cpin_b;
  logic [9:0] din_b;
  logic       outvalid_b;
  logic [9:0] dout0_b;
  logic [9:0] dout1_b;
  logic [9:0] dout2_b;
  logic       seqerr_b;
  logic [7:0] errcnt_b;

  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  int   ov_cnt;
  pix_t q_a[$];
  pix_t q_b[$];

  gamma_cp_deserializer #(
    .DATA_WIDTH(10), .CPSEL_WIDTH(2), .NUM_CP(3), .ERRCNT_WIDTH(8)
  ) u_dut3 (
    .clk(clk), .rstn(rstn), .ce(ce), .inpvalid(inpvalid_a), .cpin(cpin_a), .din(din_a),
    .clr_err(clr_err), .outvalid(outvalid_a), .dout0(dout0_a), .dout1(dout1_a),
    .dout2(dout2_a), .seqerr(seqerr_a), .errcnt(errcnt_a)
  );

  gamma_cp_deserializer #(
    .DATA_WIDTH(10), .CPSEL_WIDTH(2), .NUM_CP(2), .ERRCNT_WIDTH(8)
  ) u_dut2 (
    .clk(clk), .rstn(rstn), .ce(ce), .inpvalid(inpvalid_b), .cpin(cpin_b), .din(din_b),
    .clr_err(clr_err), .outvalid(outvalid_b), .dout0(dout0_b), .dout1(dout1_b),
    .dout2(dout2_b), .seqerr(seqerr_b), .errcnt(errcnt_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives one plane for exactly one clock edge; returns just after that edge.
  task automatic applyStimulus(input bit to_b, input logic [1:0] cp, input logic [9:0] d);
    if (to_b) begin
      inpvalid_b = 1'b1; cpin_b = cp; din_b = d;
    end else begin
      inpvalid_a = 1'b1; cpin_a = cp; din_a = d;
    end
    @(posedge clk);
    #1;
    inpvalid_a = 1'b0;
    inpvalid_b = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called just before the final plane is driven; timed entries expect outvalid one edge later.
  task automatic expectPixel(input bit to_b, input logic [9:0] a, input logic [9:0] b,
                             input logic [9:0] c, input bit timed);
    pix_t p;
    p.d0  = a;
    p.d1  = b;
    p.d2  = c;
    p.cyc = timed ? cyc + 1 : -1;
    if (to_b) q_b.push_back(p);
    else      q_a.push_back(p);
  endtask

  always @(negedge clk) begin
    pix_t p;
    if (rstn && ce && outvalid_a) begin
      if (q_a.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL unexpected_pixel_a: got {%0h,%0h,%0h}, expected no pixel", dout0_a, dout1_a, dout2_a);
      end else begin
        p = q_a.pop_front();
        checkOutput("pix_a_dout0", 32'(dout0_a), 32'(p.d0));
        checkOutput("pix_a_dout1", 32'(dout1_a), 32'(p.d1));
        checkOutput("pix_a_dout2", 32'(dout2_a), 32'(p.d2));
        if (p.cyc >= 0) checkOutput("pix_a_cycle", 32'(cyc), 32'(p.cyc));
      end
    end
    if (rstn && ce && outvalid_b) begin
      if (q_b.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL unexpected_pixel_b: got {%0h,%0h,%0h}, expected no pixel", dout0_b, dout1_b, dout2_b);
      end else begin
        p = q_b.pop_front();
        checkOutput("pix_b_dout0", 32'(dout0_b), 32'(p.d0));
        checkOutput("pix_b_dout1", 32'(dout1_b), 32'(p.d1));
        checkOutput("pix_b_dout2", 32'(dout2_b), 32'(p.d2));
        if (p.cyc >= 0) checkOutput("pix_b_cycle", 32'(cyc), 32'(p.cyc));
      end
    end
  end

  initial begin
    rstn = 1'b0; ce = 1'b1; clr_err = 1'b0;
    inpvalid_a = 1'b0; cpin_a = '0; din_a = '0;
    inpvalid_b = 1'b0; cpin_b = '0; din_b = '0;
    idle(2);
    checkOutput("rst_a_outvalid", 32'(outvalid_a), 0);
    checkOutput("rst_a_dout0", 32'(dout0_a), 0);
    checkOutput("rst_a_seqerr", 32'(seqerr_a), 0);
    checkOutput("rst_a_errcnt", 32'(errcnt_a), 0);
    rstn = 1'b1;
    idle(1);

    $display("[TB] nominal back-to-back pixels");
    applyStimulus(0, 2'd0, 10'h3FF); applyStimulus(0, 2'd1, 10'h155);
    expectPixel(0, 10'h3FF, 10'h155, 10'h000, 1); applyStimulus(0, 2'd2, 10'h000);
    applyStimulus(0, 2'd0, 10'h001); applyStimulus(0, 2'd1, 10'h002);
    expectPixel(0, 10'h001, 10'h002, 10'h003, 1); applyStimulus(0, 2'd2, 10'h003);
    applyStimulus(0, 2'd0, 10'h100); applyStimulus(0, 2'd1, 10'h200);
    expectPixel(0, 10'h100, 10'h200, 10'h300, 1); applyStimulus(0, 2'd2, 10'h300);
    idle(2);
    checkOutput("nom_seqerr", 32'(seqerr_a), 0);
    checkOutput("nom_hold_dout1", 32'(dout1_a), 32'h200);

    $display("[TB] gaps between planes and ce hold");
    applyStimulus(0, 2'd0, 10'h111); applyStimulus(0, 2'd1, 10'h222);
    idle(5);
    expectPixel(0, 10'h111, 10'h222, 10'h333, 0); applyStimulus(0, 2'd2, 10'h333);
    ov_cnt = outvalid_a ? 1 : 0;
    ce = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (outvalid_a) ov_cnt++;
    end
    ce = 1'b1;
    @(posedge clk); #1;
    checkOutput("ce_hold_outvalid_cycles", 32'(ov_cnt), 4);
    checkOutput("ce_release_outvalid", 32'(outvalid_a), 0);

    $display("[TB] resync on new plane 0");
    applyStimulus(0, 2'd0, 10'h010); applyStimulus(0, 2'd1, 10'h020);
    applyStimulus(0, 2'd0, 10'h030); applyStimulus(0, 2'd1, 10'h040);
    expectPixel(0, 10'h030, 10'h040, 10'h050, 1); applyStimulus(0, 2'd2, 10'h050);
    idle(1);
    checkOutput("resync_seqerr", 32'(seqerr_a), 1);
    checkOutput("resync_errcnt", 32'(errcnt_a), 1);

    $display("[TB] illegal and skipped tags");
    clr_err = 1'b1; idle(1); clr_err = 1'b0;
    checkOutput("clear_errcnt", 32'(errcnt_a), 0);
    applyStimulus(0, 2'd0, 10'h0AA); applyStimulus(0, 2'd2, 10'h0BB);
    applyStimulus(0, 2'd3, 10'h0CC);
    applyStimulus(0, 2'd0, 10'h1AB); applyStimulus(0, 2'd1, 10'h2CD);
    expectPixel(0, 10'h1AB, 10'h2CD, 10'h3EF, 1); applyStimulus(0, 2'd2, 10'h3EF);
    idle(1);
    checkOutput("illegal_errcnt", 32'(errcnt_a), 2);

    $display("[TB] counter saturation and clear");
    for (int i = 0; i < 300; i++) applyStimulus(0, 2'd1, 10'(i));
    checkOutput("sat_errcnt", 32'(errcnt_a), 255);
    clr_err = 1'b1;
    applyStimulus(0, 2'd1, 10'h055);
    clr_err = 1'b0;
    checkOutput("clr_with_err_errcnt", 32'(errcnt_a), 1);
    checkOutput("clr_with_err_seqerr", 32'(seqerr_a), 1);
    clr_err = 1'b1; idle(1); clr_err = 1'b0;
    checkOutput("clr_alone_errcnt", 32'(errcnt_a), 0);
    checkOutput("clr_alone_seqerr", 32'(seqerr_a), 0);

    $display("[TB] reset mid-pixel on two-plane instance");
    applyStimulus(1, 2'd0, 10'h0F0);
    rstn = 1'b0; idle(1); rstn = 1'b1;
    checkOutput("midrst_b_outvalid", 32'(outvalid_b), 0);
    checkOutput("midrst_b_dout0", 32'(dout0_b), 0);
    checkOutput("midrst_b_dout1", 32'(dout1_b), 0);
    checkOutput("midrst_b_seqerr", 32'(seqerr_b), 0);
    checkOutput("midrst_b_errcnt", 32'(errcnt_b), 0);
    checkOutput("midrst_a_dout0", 32'(dout0_a), 0);
    applyStimulus(1, 2'd1, 10'h123);
    applyStimulus(1, 2'd0, 10'h2A5);
    expectPixel(1, 10'h2A5, 10'h35A, 10'h000, 1); applyStimulus(1, 2'd1, 10'h35A);
    idle(2);
    checkOutput("midrst_b_errcnt_after", 32'(errcnt_b), 1);
    checkOutput("midrst_b_seqerr_after", 32'(seqerr_b), 1);

    checkOutput("scoreboard_a_drained", 32'(q_a.size()), 0);
    checkOutput("scoreboard_b_drained", 32'(q_b.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/gamma_cp_deserializer.md
Name: gamma_cp_deserializer

Overview:
- Sits directly downstream of the gamma corrector when it is built in serial-input architecture.
- Takes one colour plane per valid cycle (dout0 tagged by cpout) and re-assembles the planes into one parallel pixel for the parallel video output path.
- Detects broken plane sequences, drops the partial pixel, re-synchronises on the next plane 0, and reports errors with a sticky flag and a saturating counter.

Parameters:
- DATA_WIDTH, 10, width of each colour plane sample.
- CPSEL_WIDTH, 2, width of the colour-plane tag.
- NUM_CP, 3, number of planes per pixel; legal values are 2 and 3.
- ERRCNT_WIDTH, 8, width of the sequence-error counter.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset; synchronous, active-low.
- ce  in  1  clock enable; all state holds while low.
- inpvalid  in  1  plane sample valid (from gamma outvalid).
- cpin  in  CPSEL_WIDTH  plane tag of din (from gamma cpout).
- din  in  DATA_WIDTH  plane sample (from gamma dout0).
- clr_err  in  1  synchronous clear of seqerr and errcnt.
- outvalid  out  1  one-cycle pulse: pixel on dout0..dout2 is valid.
- dout0  out  DATA_WIDTH  plane 0 of the assembled pixel.
- dout1  out  DATA_WIDTH  plane 1 of the assembled pixel.
- dout2  out  DATA_WIDTH  plane 2 of the assembled pixel; tied to 0 when NUM_CP=2.
- seqerr  out  1  sticky sequence-error flag.
- errcnt  out  ERRCNT_WIDTH  saturating count of sequence errors.

Behaviour:
- Reset (rstn=0 at a clk edge):
  - state=EXP0.
  - outvalid=0; dout0/1/2=0; seqerr=0; errcnt=0.
  - Capture registers are cleared.
  - Reset takes priority over ce.
- Clock enable:
  - ce=0: every register holds, including outvalid. Downstream qualifies outvalid with ce.
  - All rules below apply only on cycles where ce=1 and rstn=1.
- State machine: EXP0, EXP1, EXP2 (EXP2 exists only when NUM_CP=3). State names the plane expected next.
- Cycle with inpvalid=0: state and capture registers hold; outvalid=0. Gaps between planes of any length are legal; there is no timeout.
- inpvalid=1 and cpin equals the expected plane:
  - The sample is captured into that plane's register.
  - The state advances EXP0->EXP1->EXP2.
  - Final plane (cpin=NUM_CP-1): state returns to EXP0. On the next edge, dout0..dout(NUM_CP-1) load the captured planes plus the current din, and outvalid=1 for exactly one cycle.
  - Latency is 1 cycle from the final plane to outvalid.
  - Back-to-back pixels at one plane per cycle give one outvalid every NUM_CP cycles.
- dout registers change only when a pixel completes. Between pulses they hold the last pixel.
- Sequence error: inpvalid=1 and cpin is not the expected plane, or cpin>=NUM_CP.
  - The partial pixel is discarded; no outvalid is produced.
  - seqerr is set to 1.
  - errcnt increments by 1 and saturates at all-ones.
  - If the offending cpin=0: it is captured as plane 0 of a new pixel and the state goes to EXP1.
  - Otherwise the state goes to EXP0.
  - cpin=0 while in EXP0 is never an error.
- clr_err=1: seqerr and errcnt clear. If an error occurs in the same cycle, the error wins: seqerr=1 and errcnt=1.
- Reset mid-pixel: partial planes are lost; the first post-reset pixel must start at plane 0.
- Widths: no arithmetic on pixel data; samples pass bit-exact.

Test Plan:
- Nominal, NUM_CP=3:
  - Stimulus: 3 pixels back-to-back as (cp,din) = (0,0x3FF)(1,0x155)(2,0x000)(0,0x001)(1,0x002)(2,0x003)(0,0x100)(1,0x200)(2,0x300).
  - Required: outvalid high on cycles 4, 7 and 10 after the first sample. dout = {0x3FF,0x155,0x000}, then {0x001,0x002,0x003}, then {0x100,0x200,0x300}. seqerr=0.
- Gaps and ce:
  - Stimulus: insert 5 idle cycles between planes 1 and 2; hold ce=0 for 3 cycles while outvalid=1.
  - Required: pixel is still correct; outvalid stays 1 for exactly the 3 held cycles plus 1.
- Resync on a new plane 0:
  - Stimulus: (0,0x010)(1,0x020)(0,0x030)(1,0x040)(2,0x050).
  - Required: exactly one outvalid, with dout={0x030,0x040,0x050}. seqerr=1, errcnt=1.
- Illegal and skipped tags:
  - Stimulus: (0,a)(2,b), then cp=3, then a full pixel.
  - Required: errcnt=2; only the full pixel is output.
- Counter saturation and clear:
  - Stimulus: 300 consecutive cp=1 samples starting from EXP0.
  - Required: errcnt=255 (ERRCNT_WIDTH=8).
  - Stimulus: clr_err together with an error, then clr_err alone.
  - Required: errcnt=1, then errcnt=0 and seqerr=0.
- Reset mid-pixel, NUM_CP=2:
  - Stimulus: (0,x), then rstn=0 for 1 cycle, then (1,y)(0,p)(1,q).
  - Required: all outputs 0 after reset. (1,y) is counted as an error. Output is {p,q} with dout2=0.
